sync_fifo_param: RTL and testbench

- Parametrised synchronous FIFO; next-generation replacement for the fixed 8x8 FIFO exercised by the fifo_property checker bench.
- Adds configurable width and depth, almost-full and almost-empty thresholds, an occupancy output, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
- Sits between any single-clock producer and consumer.
- Must stay compatible with hierarchical assertion checkers through its internal `rd_ptr`, `wr_ptr` and `cnt` signals.

---
 rtl/sync_fifo_param.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with threshold flags, sticky
// overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_write,
  input  logic                     fifo_read,
  input  logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         fifo_data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_acc, wr_acc;

  // Plain names kept visible for hierarchical assertion checkers.
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign cnt    = cnt_q;

  assign fifo_full         = (cnt == CW'(DEPTH));
  assign fifo_empty        = (cnt == {CW{1'b0}});
  assign fifo_almost_full  = (cnt >= CW'(AF_THRESH));
  assign fifo_almost_empty = (cnt <= CW'(AE_THRESH));
  assign fifo_count        = cnt;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

  // Acceptance, pointer, occupancy and sticky error next-state logic.
  always_comb begin
    rd_acc = fifo_read & ~fifo_empty;
    wr_acc = fifo_write & (~fifo_full | rd_acc);

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A fresh error in the same cycle as err_clr keeps the flag set.
    if (fifo_write & fifo_full & ~rd_acc) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (fifo_read & fifo_empty) begin
      unf_d = 1'b1;
    end else if (err_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_data_out = mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] data_q, data_d;

      // Registered read port: capture the head word on an accepted read.
      always_comb begin
        if (rd_acc) begin
          data_d = mem[rd_ptr];
        end else begin
          data_d = data_q;
        end
      end

      // Read data register.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= {WIDTH{1'b0}};
        end else begin
          data_q <= data_d;
        end
      end

      assign fifo_data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one registered-read
// instance (8x8, AF=6, AE=1) and one FWFT instance of the same geometry.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr, rd, clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, af, ae, ovf, unf;
  logic [3:0] count;

  logic       wr_f, rd_f, clr_f;
  logic [7:0] din_f;
  logic [7:0] dout_f;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [3:0] count_f;

  int total;
  int bad;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .fifo_write(wr), .fifo_read(rd), .fifo_data_in(din),
    .err_clr(clr), .fifo_data_out(dout), .fifo_full(full), .fifo_empty(empty),
    .fifo_almost_full(af), .fifo_almost_empty(ae), .fifo_count(count),
    .fifo_overflow(ovf), .fifo_underflow(unf)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .fifo_write(wr_f), .fifo_read(rd_f), .fifo_data_in(din_f),
    .err_clr(clr_f), .fifo_data_out(dout_f), .fifo_full(full_f), .fifo_empty(empty_f),
    .fifo_almost_full(af_f), .fifo_almost_empty(ae_f), .fifo_count(count_f),
    .fifo_overflow(ovf_f), .fifo_underflow(unf_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); din = 8'($urandom_range(0, 255));
      wr_f = 1'($urandom_range(0, 1)); rd_f = 1'($urandom_range(0, 1)); din_f = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1'b1; wr = 1'b1; rd = 1'b1; wr_f = 1'b1; rd_f = 1'b1;
    tick();
    tick();
    rst = 1'b0; wr = 1'b0; rd = 1'b0; wr_f = 1'b0; rd_f = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_empty_full: got empty=%0b full=%0b expected 1/0", empty, full); end
    total++; if (ae !== 1'b1 || af !== 1'b0) begin bad++; $display("FAIL reset_ae_af: got ae=%0b af=%0b expected 1/0", ae, af); end
    total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL reset_errors: got ovf=%0b unf=%0b expected 0/0", ovf, unf); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %0h expected 00", dout); end
    total++; if (dut.rd_ptr !== 3'd0 || dut.wr_ptr !== 3'd0 || dut.cnt !== 4'd0) begin bad++; $display("FAIL reset_ptrs: got rd=%0d wr=%0d cnt=%0d expected 0/0/0", dut.rd_ptr, dut.wr_ptr, dut.cnt); end
    total++; if (empty_f !== 1'b1 || count_f !== 4'd0 || ovf_f !== 1'b0 || unf_f !== 1'b0) begin bad++; $display("FAIL reset_fwft: got empty=%0b count=%0d ovf=%0b unf=%0b expected 1/0/0/0", empty_f, count_f, ovf_f, unf_f); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; din = 8'h10 + 8'(i);
      tick();
      total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
      total++; if (af !== (i + 1 >= 6)) begin bad++; $display("FAIL fill_af: got %0b expected %0b at count %0d", af, (i + 1 >= 6), i + 1); end
      total++; if (full !== (i + 1 == 8) || empty !== 1'b0) begin bad++; $display("FAIL fill_full: got full=%0b empty=%0b at count %0d", full, empty, i + 1); end
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      tick();
      total++; if (dout !== 8'h10 + 8'(i)) begin bad++; $display("FAIL drain_data: got %0h expected %0h", dout, 8'h10 + 8'(i)); end
      total++; if (count !== 4'(7 - i) || ae !== (7 - i <= 1)) begin bad++; $display("FAIL drain_count: got count=%0d ae=%0b expected %0d", count, ae, 7 - i); end
    end
    rd = 1'b0;
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL drain_empty: got empty=%0b full=%0b expected 1/0", empty, full); end
    total++; if (dut.rd_ptr !== 3'd0 || dut.wr_ptr !== 3'd0) begin bad++; $display("FAIL drain_wrap: got rd=%0d wr=%0d expected 0/0", dut.rd_ptr, dut.wr_ptr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; din = 8'h20 + 8'(i);
      tick();
    end
    din = 8'hAA;
    tick();
    wr = 1'b0;
    total++; if (dut.wr_ptr !== 3'd0 || count !== 4'd8) begin bad++; $display("FAIL ovf_state: got wr_ptr=%0d count=%0d expected 0/8", dut.wr_ptr, count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b expected 1", ovf); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b expected 0", ovf); end
  endtask

  task automatic test_simul_full();
    wr = 1'b1; rd = 1'b1; din = 8'h30;
    tick();
    wr = 1'b0; rd = 1'b0;
    total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL simfull_count: got count=%0d full=%0b expected 8/1", count, full); end
    total++; if (dout !== 8'h20) begin bad++; $display("FAIL simfull_data: got %0h expected 20", dout); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL simfull_ovf: got %0b expected 0", ovf); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 7) ? 8'h21 + 8'(i) : 8'h30;
      rd = 1'b1;
      tick();
      total++; if (dout !== exp_d) begin bad++; $display("FAIL simfull_drain: got %0h expected %0h", dout, exp_d); end
    end
    rd = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL simfull_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_underflow();
    wr = 1'b1; rd = 1'b1; din = 8'h5A;
    tick();
    wr = 1'b0; rd = 1'b0;
    total++; if (count !== 4'd1 || dut.rd_ptr !== 3'd1) begin bad++; $display("FAIL unf_state: got count=%0d rd_ptr=%0d expected 1/1", count, dut.rd_ptr); end
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_flag: got %0b expected 1", unf); end
    rd = 1'b1; clr = 1'b1;
    tick();
    total++; if (dout !== 8'h5A || empty !== 1'b1) begin bad++; $display("FAIL unf_read: got data=%0h empty=%0b expected 5a/1", dout, empty); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_clear: got %0b expected 0", unf); end
    tick();
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_err_wins: got %0b expected 1", unf); end
    rd = 1'b0;
    tick();
    clr = 1'b0;
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_clear2: got %0b expected 0", unf); end
  endtask

  task automatic test_fwft();
    wr_f = 1'b1; din_f = 8'h33;
    tick();
    wr_f = 1'b0;
    total++; if (dout_f !== 8'h33 || empty_f !== 1'b0 || count_f !== 4'd1) begin bad++; $display("FAIL fwft_first: got data=%0h empty=%0b count=%0d expected 33/0/1", dout_f, empty_f, count_f); end
    wr_f = 1'b1; din_f = 8'h44;
    tick();
    wr_f = 1'b0;
    total++; if (dout_f !== 8'h33 || count_f !== 4'd2) begin bad++; $display("FAIL fwft_hold: got data=%0h count=%0d expected 33/2", dout_f, count_f); end
    rd_f = 1'b1;
    tick();
    total++; if (dout_f !== 8'h44 || count_f !== 4'd1) begin bad++; $display("FAIL fwft_next: got data=%0h count=%0d expected 44/1", dout_f, count_f); end
    tick();
    rd_f = 1'b0;
    total++; if (empty_f !== 1'b1 || unf_f !== 1'b0) begin bad++; $display("FAIL fwft_empty: got empty=%0b unf=%0b expected 1/0", empty_f, unf_f); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 8'h01 + 8'(i);
      tick();
    end
    wr = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL midrst_state: got count=%0d empty=%0b expected 0/1", count, empty); end
    wr = 1'b1; din = 8'h77;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    total++; if (dout !== 8'h77 || empty !== 1'b1) begin bad++; $display("FAIL midrst_data: got data=%0h empty=%0b expected 77/1", dout, empty); end
  endtask

  task automatic test_wrap_stress();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int mcnt, nw, nr;
    logic movf, munf, m_rd, m_wr, w, r;
    logic [7:0] d;
    mcnt = 0; nw = 0; nr = 0; movf = 1'b0; munf = 1'b0; exp_d = 8'h00;
    for (int i = 0; i < 100; i++) begin
      w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255));
      m_rd = r && (mcnt != 0);
      m_wr = w && ((mcnt != 8) || m_rd);
      if (w && mcnt == 8 && !m_rd) movf = 1'b1;
      if (r && mcnt == 0) munf = 1'b1;
      if (m_rd) begin exp_d = q.pop_front(); nr++; end
      if (m_wr) begin q.push_back(d); nw++; end
      mcnt = mcnt + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
      wr = w; rd = r; din = d;
      tick();
      total++; if (count !== 4'(mcnt)) begin bad++; $display("FAIL stress_count: got %0d expected %0d at cycle %0d", count, mcnt, i); end
      total++; if (full !== (mcnt == 8) || empty !== (mcnt == 0) || af !== (mcnt >= 6) || ae !== (mcnt <= 1)) begin bad++; $display("FAIL stress_flags: got f=%0b e=%0b af=%0b ae=%0b count %0d", full, empty, af, ae, mcnt); end
      total++; if (ovf !== movf || unf !== munf) begin bad++; $display("FAIL stress_errors: got ovf=%0b unf=%0b expected %0b/%0b", ovf, unf, movf, munf); end
      if (m_rd) begin
        total++; if (dout !== exp_d) begin bad++; $display("FAIL stress_data: got %0h expected %0h at cycle %0d", dout, exp_d, i); end
      end
    end
    wr = 1'b0; rd = 1'b0;
    total++; if (dut.cnt !== 4'(nw - nr)) begin bad++; $display("FAIL stress_cnt_balance: got %0d expected %0d", dut.cnt, nw - nr); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
    wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0; din_f = 8'h00;
    tick();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simul_full();
    test_underflow();
    test_fwft();
    test_reset_midop();
    test_wrap_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
